// File: rtl/demux_pkg.sv
// Shared helpers for the demux family: channel count, credit width, slot offsets.
package demux_pkg;

    // Number of channels addressed by a select of the given width.
    function automatic int num_ch(input int sel_width);
        return 1 << sel_width;
    endfunction

    // Counter width able to hold 0..cmax without wrapping.
    function automatic int credit_width(input int cmax);
        return $clog2(cmax + 1);
    endfunction

    // LSB of slot idx within a flattened bus of dat_width-wide slots.
    function automatic int slot_lsb(input int idx, input int dat_width);
        return idx * dat_width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester above last_grant, wrapping.
// N is expected to be a power of two so the index addition wraps naturally.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    logic [IDX_W-1:0] idx;

    // Walk from last_grant+1 upward; the first requester seen wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 1; k <= int'(N); k++) begin
            idx = last_grant + IDX_W'(k);
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_sched.sv
// Credit-based round-robin scheduler feeding a registered one-hot 1-to-N demux.
module demux_rr_sched
    import demux_pkg::*;
#(
    parameter int unsigned DAT_WIDTH  = 8,
    parameter int unsigned SEL_WIDTH  = 2,
    parameter int unsigned CREDIT_MAX = 4,
    localparam int unsigned N          = num_ch(SEL_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DAT_WIDTH-1:0]   in_data,
    input  logic [N-1:0]           ch_enable,
    input  logic [N-1:0]           credit_ret,
    output logic [N-1:0]           out_valid,
    output logic [N*DAT_WIDTH-1:0] out_data,
    output logic [SEL_WIDTH-1:0]   out_sel,
    output logic                   credit_err
);

    localparam int unsigned CW = credit_width(CREDIT_MAX);
    localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);

    logic [CW-1:0]          credit [N];
    logic [N-1:0]           eligible;
    logic [N-1:0]           over_ret;
    logic [N-1:0]           grant;
    logic [SEL_WIDTH-1:0]   grant_idx;
    logic [SEL_WIDTH-1:0]   last_grant;
    logic                   any_grant;
    logic                   accept;
    logic [N*DAT_WIDTH-1:0] slot_data;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req        (eligible),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_grant  (any_grant)
    );

    assign in_ready = any_grant;
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < int'(N); i++) begin : g_credit
        logic dispatch;
        assign dispatch    = accept && grant[i];
        assign eligible[i] = ch_enable[i] && (credit[i] != '0);
        // A return at the ceiling is an error unless this cycle also spends a credit.
        assign over_ret[i] = credit_ret[i] && !dispatch && (credit[i] == CMAX);

        // Per-channel credit counter: dispatch spends, return refills, both cancel.
        always_ff @(posedge clk) begin
            if (rst) begin
                credit[i] <= CMAX;
            end else if (dispatch && !credit_ret[i]) begin
                credit[i] <= credit[i] - CW'(1);
            end else if (!dispatch && credit_ret[i] && (credit[i] != CMAX)) begin
                credit[i] <= credit[i] + CW'(1);
            end
        end
    end

    // Slot fan-out: place the input word in the granted slot, zeros elsewhere.
    always_comb begin
        slot_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (grant[i]) begin
                slot_data[slot_lsb(i, DAT_WIDTH) +: DAT_WIDTH] = in_data;
            end
        end
    end

    // Round-robin pointer; reset to N-1 so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= '1;
        end else if (accept) begin
            last_grant <= grant_idx;
        end
    end

    // Output register: valid pulses for one cycle, data and select hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (accept) begin
            out_valid <= grant;
            out_data  <= slot_data;
            out_sel   <= grant_idx;
        end else begin
            out_valid <= '0;
        end
    end

    // Sticky over-return flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_err <= 1'b0;
        end else if (|over_ret) begin
            credit_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched with CREDIT_MAX=2: table-driven vectors plus a reset sequence.
module tb_demux_rr_sched;

    localparam int DW = 8;
    localparam int SW = 2;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [NC-1:0] ch_enable;
    logic [NC-1:0] credit_ret;
    logic [NC-1:0] out_valid;
    logic [NC*DW-1:0] out_data;
    logic [SW-1:0] out_sel;
    logic          credit_err;

    int checks = 0;
    int errors = 0;

    demux_rr_sched #(
        .DAT_WIDTH  (DW),
        .SEL_WIDTH  (SW),
        .CREDIT_MAX (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .ch_enable  (ch_enable),
        .credit_ret (credit_ret),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          valid;
        logic [DW-1:0] data;
        logic [NC-1:0] en;
        logic [NC-1:0] ret;
        logic          exp_ready;
        logic [NC-1:0] exp_ov;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [NC-1:0]    ov;
        logic [SW-1:0]    sel;
        logic [NC*DW-1:0] data;
        logic             err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    logic [SW-1:0]    hold_sel;
    logic [NC*DW-1:0] hold_data;

    function automatic vec_t mk(input logic r, input logic v, input logic [DW-1:0] d,
                                input logic [NC-1:0] en, input logic [NC-1:0] ret,
                                input logic rdy, input logic [NC-1:0] ov, input logic err);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.en = en; x.ret = ret;
        x.exp_ready = rdy; x.exp_ov = ov; x.exp_err = err;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive one cycle, check in_ready, queue the expected registered result, then compare it.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t g;
        rst        = v.rst;
        in_valid   = v.valid;
        in_data    = v.data;
        ch_enable  = v.en;
        credit_ret = v.ret;
        #1;
        if (!v.rst) check("in_ready", 64'(in_ready), 64'(v.exp_ready));
        e.ov  = v.exp_ov;
        e.err = v.exp_err;
        if (v.rst) begin
            hold_sel  = '0;
            hold_data = '0;
        end else if (v.exp_ov != '0) begin
            hold_data = '0;
            for (int i = 0; i < NC; i++) begin
                if (v.exp_ov[i]) begin
                    hold_sel = SW'(i);
                    hold_data[i*DW +: DW] = v.data;
                end
            end
        end
        e.sel  = hold_sel;
        e.data = hold_data;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("out_valid", 64'(out_valid), 64'(g.ov));
        check("out_sel", 64'(out_sel), 64'(g.sel));
        check("out_data", 64'(out_data), 64'(g.data));
        check("credit_err", 64'(credit_err), 64'(g.err));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; ch_enable = '1; credit_ret = '0;
        hold_sel = '0; hold_data = '0;

        // Reset, then round-robin over 8 words until every credit is spent.
        vecs.push_back(mk(1, 0, 8'h00, 4'hF, 4'h0, 0, 4'h0, 0));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(0, 1, 8'(8'h10 + k), 4'hF, 4'h0, 1, 4'(1 << (k % 4)), 0));
        vecs.push_back(mk(0, 1, 8'h18, 4'hF, 4'h0, 0, 4'h0, 0));
        // Credit return on channel 2 reopens exactly one slot.
        vecs.push_back(mk(0, 0, 8'h00, 4'hF, 4'h4, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 8'h20, 4'hF, 4'h0, 1, 4'h4, 0));
        vecs.push_back(mk(0, 1, 8'h21, 4'hF, 4'h0, 0, 4'h0, 0));
        // Dispatch and return on channel 1 in the same cycle leave its credit at 1.
        vecs.push_back(mk(0, 0, 8'h00, 4'hF, 4'h2, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 8'h30, 4'hF, 4'h2, 1, 4'h2, 0));
        vecs.push_back(mk(0, 1, 8'h31, 4'hF, 4'h0, 1, 4'h2, 0));
        vecs.push_back(mk(0, 1, 8'h32, 4'hF, 4'h0, 0, 4'h0, 0));
        // Mask 1010: only channels 1 and 3 are granted.
        vecs.push_back(mk(1, 0, 8'h00, 4'hF, 4'h0, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 8'h40, 4'hA, 4'h0, 1, 4'h2, 0));
        vecs.push_back(mk(0, 1, 8'h41, 4'hA, 4'h0, 1, 4'h8, 0));
        vecs.push_back(mk(0, 1, 8'h42, 4'hA, 4'h0, 1, 4'h2, 0));
        vecs.push_back(mk(0, 1, 8'h43, 4'hA, 4'h0, 1, 4'h8, 0));
        vecs.push_back(mk(0, 1, 8'h44, 4'hA, 4'h0, 0, 4'h0, 0));
        // Over-return on full channel 0 sets the sticky error.
        vecs.push_back(mk(0, 0, 8'h00, 4'hA, 4'h1, 0, 4'h0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 4'hA, 4'h0, 0, 4'h0, 1));
        // Re-enable all: channel 0 kept its credits, then channel 2 is next.
        vecs.push_back(mk(0, 1, 8'h50, 4'hF, 4'h0, 1, 4'h1, 1));
        vecs.push_back(mk(0, 1, 8'h51, 4'hF, 4'h0, 1, 4'h4, 1));

        @(posedge clk);
        #1;
        foreach (vecs[i]) step(vecs[i]);

        // Reset while out_valid=0100; returns during reset must be ignored.
        check("pre_reset_out_valid", 64'(out_valid), 64'h4);
        step(mk(1, 1, 8'h99, 4'hF, 4'hF, 0, 4'h0, 0));
        for (int k = 0; k < 8; k++)
            step(mk(0, 1, 8'(8'h60 + k), 4'hF, 4'h0, 1, 4'(1 << (k % 4)), 0));
        step(mk(0, 1, 8'h68, 4'hF, 4'h0, 0, 4'h0, 0));

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
